// File: rtl/ofs_fim_pcie_ss_sb_tx_arb_pkg.sv
// Shared types and round-robin pick for the side-band TX stream arbiter.
// Beat fields are sized for the largest supported configuration; narrower builds zero-pad.
package ofs_fim_pcie_ss_sb_tx_arb_pkg;

   localparam int MAX_PORTS   = 16;
   localparam int PORT_W      = 4;
   localparam int BEAT_DATA_W = 512;
   localparam int BEAT_HDR_W  = 256;
   localparam int BEAT_USER_W = BEAT_HDR_W + 1;

   typedef enum logic {IDLE, LOCKED} t_arb_state;

   typedef struct packed {
      logic [BEAT_DATA_W-1:0]   data;
      logic [BEAT_DATA_W/8-1:0] keep;
      logic                     last;
      logic [BEAT_USER_W-1:0]   user;
      logic [PORT_W-1:0]        port;
   } t_beat;

   // First set bit of valid at or after ptr, searching cyclically over n ports
   function automatic logic [PORT_W-1:0] rr_pick(input logic [MAX_PORTS-1:0] valid,
                                                 input logic [PORT_W-1:0]    ptr,
                                                 input int                   n);
      logic [PORT_W-1:0] pick;
      logic              found;
      int                idx;
      pick  = '0;
      found = 1'b0;
      for (int i = 0; i < MAX_PORTS; i++) begin
         idx = (int'(ptr) + i) % n;
         if (!found && i < n && valid[idx[PORT_W-1:0]]) begin
            pick  = idx[PORT_W-1:0];
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/ofs_fim_pcie_ss_sb_tx_arb_skid.sv
// Two-entry AXI-S skid buffer on t_beat; in_ready is registered so the
// downstream ready never reaches the upstream ready combinationally.
module ofs_fim_pcie_ss_sb_tx_skid
   import ofs_fim_pcie_ss_sb_tx_arb_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  in_valid,
   output logic  in_ready,
   input  t_beat in_beat,
   output logic  out_valid,
   input  logic  out_ready,
   output t_beat out_beat
);

   logic  skid_valid;
   t_beat skid_beat;

   assign in_ready = ~skid_valid;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
         out_beat   <= '0;
         skid_beat  <= '0;
      end else if (!out_valid || out_ready) begin
         if (skid_valid) begin
            out_beat   <= skid_beat;
            out_valid  <= 1'b1;
            skid_valid <= 1'b0;
         end else begin
            out_valid <= in_valid;
            if (in_valid) out_beat <= in_beat;
         end
      end else if (in_valid && !skid_valid) begin
         skid_beat  <= in_beat;
         skid_valid <= 1'b1;
      end
   end

endmodule

// File: rtl/ofs_fim_pcie_ss_sb_tx_arb.sv
// Packet-granular round-robin merge of side-band-header PCIe SS TX streams.
// Optional per-port packet counters: define OFS_FIM_PCIE_SS_TX_ARB_STATS_EN.
module ofs_fim_pcie_ss_sb_tx_arb
   import ofs_fim_pcie_ss_sb_tx_arb_pkg::*;
#(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_WIDTH = 512,
   parameter int HDR_WIDTH  = 256,
   parameter int USER_W     = 1 + HDR_WIDTH
)(
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_PORTS-1:0]              in_tvalid,
   output logic [NUM_PORTS-1:0]              in_tready,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]   in_tdata,
   input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] in_tkeep,
   input  logic [NUM_PORTS-1:0]              in_tlast,
   input  logic [NUM_PORTS*USER_W-1:0]       in_tuser_vendor,
   output logic                              out_tvalid,
   input  logic                              out_tready,
   output logic [DATA_WIDTH-1:0]             out_tdata,
   output logic [DATA_WIDTH/8-1:0]           out_tkeep,
   output logic                              out_tlast,
   output logic [USER_W-1:0]                 out_tuser_vendor,
   output logic [$clog2(NUM_PORTS)-1:0]      out_port,
   output logic [NUM_PORTS*32-1:0]           stat_pkt_cnt
);

   localparam int PW = $clog2(NUM_PORTS);
   localparam int KW = DATA_WIDTH / 8;

   t_arb_state        state;
   logic [PORT_W-1:0] rr_ptr;
   logic [PORT_W-1:0] grant;
   logic [PORT_W-1:0] cur;
   logic              buf_ready;
   logic              acc;
   logic              any_valid;
   t_beat             in_beat;
   t_beat             out_beat;

   assign any_valid = |in_tvalid;
   assign acc       = |(in_tvalid & in_tready);

   // While LOCKED the grant is frozen; in IDLE it follows the live arbitration
   always_comb begin
      cur = (state == LOCKED) ? grant : rr_pick(MAX_PORTS'(in_tvalid), rr_ptr, NUM_PORTS);
      for (int i = 0; i < NUM_PORTS; i++)
         in_tready[i] = rst_n & buf_ready & (cur == PORT_W'(i)) & ((state == LOCKED) | any_valid);
      in_beat = '0;
      in_beat.data[DATA_WIDTH-1:0] = in_tdata[cur*DATA_WIDTH +: DATA_WIDTH];
      in_beat.keep[KW-1:0]         = in_tkeep[cur*KW +: KW];
      in_beat.last                 = in_tlast[cur[PW-1:0]];
      in_beat.user[USER_W-1:0]     = in_tuser_vendor[cur*USER_W +: USER_W];
      in_beat.port                 = cur;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         rr_ptr <= '0;
         grant  <= '0;
      end else if (acc) begin
         if (in_beat.last) begin
            state  <= IDLE;
            rr_ptr <= (cur == PORT_W'(NUM_PORTS-1)) ? '0 : cur + 1'b1;
         end else begin
            state <= LOCKED;
            grant <= cur;
         end
      end
   end

   ofs_fim_pcie_ss_sb_tx_skid u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (acc),
      .in_ready  (buf_ready),
      .in_beat   (in_beat),
      .out_valid (out_tvalid),
      .out_ready (out_tready),
      .out_beat  (out_beat)
   );

   assign out_tdata        = out_beat.data[DATA_WIDTH-1:0];
   assign out_tkeep        = out_beat.keep[KW-1:0];
   assign out_tlast        = out_beat.last;
   assign out_tuser_vendor = out_beat.user[USER_W-1:0];
   assign out_port         = out_beat.port[PW-1:0];

   // Padding bits of the wide beat are intentionally dropped
   logic unused_beat_bits;
   assign unused_beat_bits = ^out_beat;

`ifdef OFS_FIM_PCIE_SS_TX_ARB_STATS_EN
   logic [NUM_PORTS-1:0][31:0] pkt_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n)
         pkt_cnt <= '0;
      else if (out_tvalid && out_tready && out_tlast)
         pkt_cnt[out_port] <= pkt_cnt[out_port] + 32'd1;
   end

   assign stat_pkt_cnt = pkt_cnt;
`else
   assign stat_pkt_cnt = '0;
`endif

endmodule
